// File: rtl/mem_stage_pipe_if.sv
// Execute-to-Memory handshake and MEM/WB result bundle for mem_stage_pipe.
// master = upstream/driver side, slave = the memory stage.
interface mem_stage_pipe_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] addr;
  logic [W-1:0] data_in;
  logic         mem_en;
  logic         mem_wr;
  logic [W-1:0] pc_in;
  logic [W-1:0] jmp_off;
  logic         brch_taken;
  logic         alu_jmp;
  logic         wb_in;
  logic         regsrc_in;
  logic         setrd_in;
  logic         out_valid;
  logic [W-1:0] pc_next;
  logic         pc_redirect;
  logic [W-1:0] out_alu;
  logic [W-1:0] out_rdata;
  logic         out_wb;
  logic         out_regsrc;
  logic         out_setrd;
  logic         err;

  modport master (
    output in_valid, addr, data_in, mem_en, mem_wr, pc_in, jmp_off,
           brch_taken, alu_jmp, wb_in, regsrc_in, setrd_in,
    input  in_ready, out_valid, pc_next, pc_redirect, out_alu, out_rdata,
           out_wb, out_regsrc, out_setrd, err
  );

  modport slave (
    input  in_valid, addr, data_in, mem_en, mem_wr, pc_in, jmp_off,
           brch_taken, alu_jmp, wb_in, regsrc_in, setrd_in,
    output in_ready, out_valid, pc_next, pc_redirect, out_alu, out_rdata,
           out_wb, out_regsrc, out_setrd, err
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// Registered Memory stage: next-PC resolution, multi-cycle data memory, MEM/WB register.
// Optional macro MEM_ALIGN_CHK_EN: odd-address memory ops complete at once with err=1.
//
// state | meaning
// IDLE  | ready to accept; non-memory ops (or LAT==1) complete at the accept edge
// BUSY  | memory access in flight, cnt_q counts down to completion
module mem_stage_pipe #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int LAT   = 3
) (
  input logic              clk,
  input logic              rst,
  mem_stage_pipe_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            complete;
  logic            accept;
  logic            misalign;

  logic [W-1:0]    s_addr_q, s_data_q, s_pc_q, s_off_q;
  logic            s_wr_q, s_brch_q, s_jmp_q, s_wb_q, s_regsrc_q, s_setrd_q;

  logic [W-1:0]    src_addr, src_data, src_pc, src_off;
  logic            src_wr, src_brch, src_jmp, src_wb, src_regsrc, src_setrd, src_mem;
  logic [AW-1:0]   idx;
  logic [W-1:0]    pc_d, rdata_d;

  logic [W-1:0]    mem_q [DEPTH];

  logic            out_valid_q, pc_redirect_q, out_wb_q, out_regsrc_q, out_setrd_q;
  logic [W-1:0]    pc_next_q, out_alu_q, out_rdata_q;

`ifdef MEM_ALIGN_CHK_EN
  logic            err_q;
  assign misalign = bus.mem_en & bus.addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign accept = bus.in_valid & (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.mem_en && !misalign && (LAT > 1)) begin
            state_d = BUSY;
            cnt_d   = CW'(LAT - 1);
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion in IDLE uses the live inputs; completion in BUSY uses the captured slot.
  always_comb begin
    if (state_q == IDLE) begin
      src_addr   = bus.addr;
      src_data   = bus.data_in;
      src_pc     = bus.pc_in;
      src_off    = bus.jmp_off;
      src_wr     = bus.mem_wr;
      src_brch   = bus.brch_taken;
      src_jmp    = bus.alu_jmp;
      src_wb     = bus.wb_in;
      src_regsrc = bus.regsrc_in;
      src_setrd  = bus.setrd_in;
      src_mem    = bus.mem_en & ~misalign;
    end else begin
      src_addr   = s_addr_q;
      src_data   = s_data_q;
      src_pc     = s_pc_q;
      src_off    = s_off_q;
      src_wr     = s_wr_q;
      src_brch   = s_brch_q;
      src_jmp    = s_jmp_q;
      src_wb     = s_wb_q;
      src_regsrc = s_regsrc_q;
      src_setrd  = s_setrd_q;
      src_mem    = 1'b1;
    end
    idx     = src_addr[AW:1];
    pc_d    = src_jmp ? src_addr : (src_brch ? src_pc + src_off : src_pc);
    rdata_d = (src_mem && !src_wr) ? mem_q[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst && complete && src_mem && src_wr) mem_q[idx] <= src_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      pc_next_q     <= '0;
      pc_redirect_q <= 1'b0;
      out_alu_q     <= '0;
      out_rdata_q   <= '0;
      out_wb_q      <= 1'b0;
      out_regsrc_q  <= 1'b0;
      out_setrd_q   <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= complete;
      if (accept) begin
        s_addr_q   <= bus.addr;
        s_data_q   <= bus.data_in;
        s_pc_q     <= bus.pc_in;
        s_off_q    <= bus.jmp_off;
        s_wr_q     <= bus.mem_wr;
        s_brch_q   <= bus.brch_taken;
        s_jmp_q    <= bus.alu_jmp;
        s_wb_q     <= bus.wb_in;
        s_regsrc_q <= bus.regsrc_in;
        s_setrd_q  <= bus.setrd_in;
      end
      if (complete) begin
        pc_next_q     <= pc_d;
        pc_redirect_q <= src_jmp | src_brch;
        out_alu_q     <= src_addr;
        out_rdata_q   <= rdata_d;
        out_wb_q      <= src_wb;
        out_regsrc_q  <= src_regsrc;
        out_setrd_q   <= src_setrd;
`ifdef MEM_ALIGN_CHK_EN
        err_q         <= (state_q == IDLE) & misalign;
`endif
      end
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.pc_redirect = pc_redirect_q;
  assign bus.out_alu     = out_alu_q;
  assign bus.out_rdata   = out_rdata_q;
  assign bus.out_wb      = out_wb_q;
  assign bus.out_regsrc  = out_regsrc_q;
  assign bus.out_setrd   = out_setrd_q;
`ifdef MEM_ALIGN_CHK_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe (W=16, DEPTH=256, LAT=3); inputs driven and
// outputs sampled on the falling edge.
module tb_mem_stage_pipe;
  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mem_stage_pipe_if #(.W(16)) bus();

  mem_stage_pipe #(.W(16), .DEPTH(256), .LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp_v);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic men,
                       input logic mwr, input logic [15:0] pc, input logic [15:0] off,
                       input logic br, input logic jmp);
    bus.addr       = a;
    bus.data_in    = d;
    bus.mem_en     = men;
    bus.mem_wr     = mwr;
    bus.pc_in      = pc;
    bus.jmp_off    = off;
    bus.brch_taken = br;
    bus.alu_jmp    = jmp;
    bus.in_valid   = 1'b1;
  endtask

  // Issue one instruction and stop on the cycle out_valid rises, checking stall and latency.
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] d,
                    input logic men, input logic mwr, input logic [15:0] pc,
                    input logic [15:0] off, input logic br, input logic jmp, input int exp_lat);
    int n;
    drive(a, d, men, mwr, pc, off, br, jmp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      chk({tag, "_stall"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.wb_in     = 1'b0;
    bus.regsrc_in = 1'b0;
    bus.setrd_in  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pc", 32'(bus.pc_next), 32'h0);
    chk("rst_rdata", 32'(bus.out_rdata), 32'h0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // store then load
    op("st1", 16'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h0040, 16'h0, 1'b0, 1'b0, 3);
    chk("st1_rdata", 32'(bus.out_rdata), 32'h0);
    chk("st1_pc", 32'(bus.pc_next), 32'h0040);
    chk("st1_redir", 32'(bus.pc_redirect), 32'd0);
    chk("st1_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    chk("st1_pulse", 32'(bus.out_valid), 32'd0);
    bus.wb_in = 1'b1;
    bus.regsrc_in = 1'b1;
    op("ld1", 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0, 1'b0, 1'b0, 3);
    chk("ld1_rdata", 32'(bus.out_rdata), 32'hBEEF);
    chk("ld1_alu", 32'(bus.out_alu), 32'h0010);
    chk("ld1_wb", 32'(bus.out_wb), 32'd1);
    chk("ld1_regsrc", 32'(bus.out_regsrc), 32'd1);
    chk("ld1_setrd", 32'(bus.out_setrd), 32'd0);
    bus.regsrc_in = 1'b0;

    // three back-to-back ALU ops
    bus.setrd_in = 1'b1;
    drive(16'h1234, 16'h0, 1'b0, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_valid", 32'(bus.out_valid), 32'd1);
      chk("alu_ready", 32'(bus.in_ready), 32'd1);
      chk("alu_out", 32'(bus.out_alu), 32'h1234);
      chk("alu_wb", 32'(bus.out_wb), 32'd1);
      chk("alu_setrd", 32'(bus.out_setrd), 32'd1);
      chk("alu_rdata", 32'(bus.out_rdata), 32'h0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("alu_idle", 32'(bus.out_valid), 32'd0);
    bus.wb_in = 1'b0;
    bus.setrd_in = 1'b0;

    // branch / jump resolution
    op("br", 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0100, 16'hFFFC, 1'b1, 1'b0, 1);
    chk("br_pc", 32'(bus.pc_next), 32'h00FC);
    chk("br_redir", 32'(bus.pc_redirect), 32'd1);
    op("jb", 16'h0200, 16'h0, 1'b0, 1'b0, 16'h0100, 16'hFFFC, 1'b1, 1'b1, 1);
    chk("jb_pc", 32'(bus.pc_next), 32'h0200);
    chk("jb_redir", 32'(bus.pc_redirect), 32'd1);
    op("seq", 16'h0200, 16'h0, 1'b0, 1'b0, 16'h0100, 16'hFFFC, 1'b0, 1'b0, 1);
    chk("seq_pc", 32'(bus.pc_next), 32'h0100);
    chk("seq_redir", 32'(bus.pc_redirect), 32'd0);
    op("jmp", 16'h0300, 16'h0, 1'b0, 1'b0, 16'h0100, 16'h0010, 1'b0, 1'b1, 1);
    chk("jmp_pc", 32'(bus.pc_next), 32'h0300);
    chk("jmp_redir", 32'(bus.pc_redirect), 32'd1);
    op("brwrap", 16'h0000, 16'h0, 1'b0, 1'b0, 16'hFFFE, 16'h0004, 1'b1, 1'b0, 1);
    chk("brwrap_pc", 32'(bus.pc_next), 32'h0002);

    // address wrap modulo DEPTH words
    op("stw", 16'h0202, 16'h5A5A, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 3);
    op("ldw", 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 3);
    chk("ldw_rdata", 32'(bus.out_rdata), 32'h5A5A);

    // reset while BUSY abandons the store
    drive(16'h0002, 16'h1111, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rb_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_ready", 32'(bus.in_ready), 32'd1);
    chk("rb_valid", 32'(bus.out_valid), 32'd0);
    chk("rb_rdata", 32'(bus.out_rdata), 32'h0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rb_novalid", 32'(bus.out_valid), 32'd0);
    end
    op("ldr", 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 3);
    chk("ldr_rdata", 32'(bus.out_rdata), 32'h5A5A);

    // odd-address store
`ifdef MEM_ALIGN_CHK_EN
    op("mis", 16'h0011, 16'h7777, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_rdata", 32'(bus.out_rdata), 32'h0);
    op("mld", 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 3);
    chk("mld_rdata", 32'(bus.out_rdata), 32'hBEEF);
    chk("mld_err", 32'(bus.err), 32'd0);
`else
    op("mis", 16'h0011, 16'h7777, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 3);
    chk("mis_err", 32'(bus.err), 32'd0);
    op("mld", 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 3);
    chk("mld_rdata", 32'(bus.out_rdata), 32'h7777);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
